beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Pattern generator that sits directly upstream of the output monostable stage and drives its `trig`/`length` inputs. On a one-cycle request it emits a train of N trigger pulses, each carrying the on-time for the monostable, spaced by a programmable gap. The result is a multi-beep / multi-flash pattern (key-click, error double-beep, overflow triple-beep) with no per-pulse involvement from the calculator control logic.

## Interface
- `CNT_W`, default 32: width of `on_len`, `gap_len` and `length`; matches the monostable `length` port.
- `N_W`, default 4: width of the beep count `beeps`.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  start request, sampled at a rising edge; accepted only in IDLE.
- `abort`  in  1  cancels the sequence in progress; has priority over `req`.
- `beeps`  in  N_W  number of pulses; sampled with `req`.
- `on_len`  in  CNT_W  pulse on-time in cycles; sampled with `req`.
- `gap_len`  in  CNT_W  off-time between pulses in cycles; sampled with `req`.
- `trig`  out  1  one-cycle trigger to the monostable; registered.
- `length`  out  CNT_W  on-time presented with `trig`; registered; holds its last value between triggers.
- `busy`  out  1  high while a sequence is active; registered.
- `done`  out  1  one-cycle pulse on normal completion; registered.

## Operation
- Reset values: `trig`=0, `length`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- States: IDLE, ON, GAP.
- IDLE, `req`=1, `beeps`≠0:
  - Latch `L` = max(`on_len`, 1). A value of 0 is clamped because the monostable needs `length` ≥ 1.
  - Latch `G` = `gap_len` and `rem` = `beeps`.
  - Next cycle: `trig`=1, `length`=L, `busy`=1, state ON, on-counter loaded with L−1.
- IDLE, `req`=1, `beeps`=0: next cycle `done`=1, no `trig`, `busy` stays 0, state stays IDLE.
- ON: the on-counter decrements each cycle. When it reaches 0, `rem` decrements and:
  - if `rem` was 1: next cycle `done`=1, `busy`=0, state IDLE;
  - else if G=0: next cycle `trig`=1 (back-to-back), stay ON, reload L−1;
  - else: state GAP, gap-counter loaded with G−1.
- GAP: the gap-counter decrements. When it reaches 0: next cycle `trig`=1, `length`=L, state ON, reload L−1.
- `req` while `busy`=1: ignored; latched parameters do not change.
- `abort`=1 in ON or GAP:
  - next cycle state IDLE, `busy`=0;
  - no `done`, no further `trig`;
  - the pulse already issued to the monostable completes on its own.
- `abort` and `req` in the same IDLE cycle: `req` is ignored.
- `trig` and `done` are never high in the same cycle.
- Counters are CNT_W bits and never wrap: a value of 0 is checked before decrementing.

## Timing
- `req` sampled at edge t. First `trig` is visible in cycle t+1; monostable `out` is high in cycles t+2 … t+1+L.
- Trigger k (k = 0 … n−1) is in cycle t+1+k·(L+G).
- `done` is in cycle t+1+(n−1)·(L+G)+L. `busy` falls in that same cycle.
- Earliest next accepted `req` is at the edge that ends the `done` cycle.
- Total `busy` time is n·L+(n−1)·G cycles.
- `Reset` asserted mid-sequence forces every output to its reset value immediately, asynchronously.

## Test plan
- Reset: assert `Reset`=0 during ON with `trig` pending → all outputs 0 at once; after release, the block sits in IDLE and no stray `trig` appears.
- Basic: `beeps`=3, `on_len`=4, `gap_len`=2, `req` at t=10:
  - `trig` at 11, 17, 23, each with `length`=4;
  - `done` at 27; `busy` high 11–26;
  - monostable `out` high 12–15, 18–21, 24–27.
- Zero gap and zero length: `beeps`=2, `on_len`=0, `gap_len`=0, `req` at t=0 → `trig` at 1 and 2 with `length`=1; `done` at 3.
- `beeps`=0, `req` at t=5 → `done` at 6; `trig` and `busy` never rise.
- Busy and abort:
  - `beeps`=4, `on_len`=3, `gap_len`=3, `req` at t=0 → trigs at 1 and 7;
  - second `req` with `beeps`=1 at t=4 → ignored;
  - `abort` at t=9 → `busy`=0 at 10; no `trig` at 13; no `done`.
- Large values: `on_len`=32'hFFFF_FFFE, `beeps`=1 → `length` equals that value and `done` arrives exactly 0xFFFF_FFFE cycles after `trig`. Verify with a forced counter preload or a reduced-CNT_W build using the same check.

Source files
------------

// File: rtl/beep_sequencer.sv
// Multi-pulse trigger generator feeding the output monostable: on a request it
// emits `beeps` triggers of on-time L separated by gaps of G cycles.
module beep_sequencer #(
   parameter int CNT_W = 32,
   parameter int N_W   = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             req,
   input  logic             abort,
   input  logic [N_W-1:0]   beeps,
   input  logic [CNT_W-1:0] on_len,
   input  logic [CNT_W-1:0] gap_len,
   output logic             trig,
   output logic [CNT_W-1:0] length,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [N_W-1:0]   ONE_N = N_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] l_len, l_nxt;
   logic [CNT_W-1:0] g_len, g_nxt;
   logic [N_W-1:0]   rem, rem_nxt;
   logic [CNT_W-1:0] length_nxt;
   logic             trig_nxt, done_nxt, busy_nxt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         cnt    <= '0;
         l_len  <= '0;
         g_len  <= '0;
         rem    <= '0;
         trig   <= 1'b0;
         length <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         l_len  <= l_nxt;
         g_len  <= g_nxt;
         rem    <= rem_nxt;
         trig   <= trig_nxt;
         length <= length_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      l_nxt      = l_len;
      g_nxt      = g_len;
      rem_nxt    = rem;
      length_nxt = length;
      trig_nxt   = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (req && !abort) begin
               if (beeps == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  // The monostable cannot fire with a zero length, so clamp to 1.
                  l_nxt      = (on_len == '0) ? ONE : on_len;
                  g_nxt      = gap_len;
                  rem_nxt    = beeps;
                  cnt_nxt    = l_nxt - ONE;
                  trig_nxt   = 1'b1;
                  length_nxt = l_nxt;
                  state_nxt  = ON;
               end
            end
         end
         ON: begin
            if (abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               rem_nxt   = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - ONE;
            end else begin
               rem_nxt = rem - ONE_N;
               if (rem == ONE_N) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else if (g_len == '0) begin
                  trig_nxt   = 1'b1;
                  length_nxt = l_len;
                  cnt_nxt    = l_len - ONE;
               end else begin
                  state_nxt = GAP;
                  cnt_nxt   = g_len - ONE;
               end
            end
         end
         GAP: begin
            if (abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               rem_nxt   = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - ONE;
            end else begin
               trig_nxt   = 1'b1;
               length_nxt = l_len;
               cnt_nxt    = l_len - ONE;
               state_nxt  = ON;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: table of request vectors checked through an event
// scoreboard, plus hand-written abort, ignored-request and reset sequences.
module tb_beep_sequencer;
   localparam int CW = 12;
   localparam int NW = 4;

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic          req = 1'b0;
   logic          abort = 1'b0;
   logic [NW-1:0] beeps = '0;
   logic [CW-1:0] on_len = '0;
   logic [CW-1:0] gap_len = '0;
   logic          trig;
   logic [CW-1:0] length;
   logic          busy;
   logic          done;

   beep_sequencer #(.CNT_W(CW), .N_W(NW)) dut (
      .Clock(Clock), .Reset(Reset), .req(req), .abort(abort), .beeps(beeps),
      .on_len(on_len), .gap_len(gap_len), .trig(trig), .length(length),
      .busy(busy), .done(done)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int            kind;   // 0 = trig, 1 = done
      int            at;
      logic [CW-1:0] len;
   } ev_t;

   typedef struct {
      logic [NW-1:0] beeps;
      logic [CW-1:0] on_len;
      logic [CW-1:0] gap_len;
      logic [CW-1:0] exp_len;
      int            period;
      int            done_off;
   } vec_t;

   ev_t           sb[$];
   vec_t          vt[7];
   int            cyc = 0;
   int            tests = 0;
   int            fails = 0;
   int            busy_lo = 1;
   int            busy_hi = 0;
   logic [CW-1:0] len_hold = '0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      ev_t ev;
      if (!Reset) return;
      while (sb.size() > 0 && sb[0].at < cyc) begin
         ev = sb.pop_front();
         check(ev.kind == 1 ? "missed_done" : "missed_trig", cyc, ev.at);
      end
      check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      check("trig_done_excl", trig & done, 0);
      if (trig || done) begin
         if (sb.size() == 0) begin
            check("unexpected_trig", trig, 0);
            check("unexpected_done", done, 0);
         end else begin
            ev = sb.pop_front();
            check(done ? "done_cycle" : "trig_cycle", cyc, ev.at);
            check("event_kind", done, ev.kind);
            if (trig) check("trig_length", length, ev.len);
            if (ev.kind == 0) len_hold = ev.len;
         end
      end else begin
         check("length_hold", length, len_hold);
      end
   endtask

   task automatic tick();
      @(negedge Clock);
      cyc++;
      monitor();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_drain(input int bound);
      int k = 0;
      while (sb.size() > 0 && k < bound) begin
         tick();
         k++;
      end
      if (sb.size() > 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic apply_vec(input vec_t v);
      int t = cyc;
      beeps   = v.beeps;
      on_len  = v.on_len;
      gap_len = v.gap_len;
      req     = 1'b1;
      for (int k = 0; k < int'(v.beeps); k++)
         sb.push_back('{0, t + 1 + k * v.period, v.exp_len});
      sb.push_back('{1, t + v.done_off, '0});
      busy_lo = t + 1;
      busy_hi = t + v.done_off - 1;
      tick();
      req = 1'b0;
   endtask

   initial begin
      int t;
      vt[0] = '{4'd3,  12'd4,    12'd2, 12'd4,    6, 17};
      vt[1] = '{4'd2,  12'd0,    12'd0, 12'd1,    1, 3};
      vt[2] = '{4'd0,  12'd5,    12'd5, 12'd5,    0, 1};
      vt[3] = '{4'd1,  12'd1,    12'd0, 12'd1,    1, 2};
      vt[4] = '{4'd4,  12'd2,    12'd1, 12'd2,    3, 12};
      vt[5] = '{4'd1,  12'hFFE,  12'd0, 12'hFFE,  1, 4095};
      vt[6] = '{4'd15, 12'd1,    12'd1, 12'd1,    2, 30};

      // Reset state
      run(3);
      check("rst_trig", trig, 0);
      check("rst_length", length, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      Reset = 1'b1;
      run(2);

      // Table vectors; each new request lands in the done cycle of the previous
      for (int i = 0; i < 7; i++) begin
         apply_vec(vt[i]);
         wait_drain(6000);
      end
      run(3);

      // Busy: second request ignored, then abort during ON
      t = cyc;
      beeps = 4'd4; on_len = 12'd3; gap_len = 12'd3; req = 1'b1;
      sb.push_back('{0, t + 1, 12'd3});
      sb.push_back('{0, t + 7, 12'd3});
      busy_lo = t + 1;
      busy_hi = t + 9;
      tick();
      req = 1'b0;
      while (cyc < t + 4) tick();
      beeps = 4'd1; on_len = 12'd7; gap_len = 12'd0; req = 1'b1;
      tick();
      req = 1'b0;
      while (cyc < t + 9) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      run(12);
      check("abort_leftover", sb.size(), 0);

      // abort and req together in IDLE: nothing happens
      beeps = 4'd2; on_len = 12'd2; gap_len = 12'd1; req = 1'b1; abort = 1'b1;
      tick();
      req = 1'b0; abort = 1'b0;
      run(8);

      // Asynchronous reset while a trigger is on the output
      t = cyc;
      apply_vec(vt[0]);
      check("pre_rst_trig", trig, 1);
      Reset = 1'b0;
      #1;
      check("async_rst_trig", trig, 0);
      check("async_rst_length", length, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      sb.delete();
      len_hold = '0;
      busy_lo = 1;
      busy_hi = 0;
      run(2);
      Reset = 1'b1;
      run(30);

      // Recovery after reset
      apply_vec(vt[4]);
      wait_drain(100);
      run(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
